// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a table of 2-bit saturating counters indexed by PC,
// with execute-stage branch resolution, a flush request and saturating statistics.
module branch_predict_unit #(
  parameter int unsigned IDX_BITS   = 4,
  parameter int unsigned CNT_W      = 16,
  parameter logic [1:0]  INIT_STATE = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_f,
  output logic             pred_taken,
  input  logic             upd_valid,
  input  logic [31:0]      pc_e,
  input  logic [2:0]       f3,
  input  logic             zero,
  input  logic             neg,
  input  logic             ltu,
  input  logic             pred_e,
  output logic             taken_e,
  output logic             mispredict,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] miss_count
);

  localparam int unsigned Entries = 1 << IDX_BITS;

  logic [1:0]          r_bht [Entries];
  logic [CNT_W-1:0]    r_br_count;
  logic [CNT_W-1:0]    r_miss_count;

  logic [IDX_BITS-1:0] w_idx_f;
  logic [IDX_BITS-1:0] w_idx_e;
  logic                w_legal;
  logic                w_cond;
  logic                w_update;
  logic [1:0]          w_entry_e;
  logic                w_unused;

  assign w_idx_f = pc_f[IDX_BITS+1:2];
  assign w_idx_e = pc_e[IDX_BITS+1:2];
  assign w_unused = ^{pc_f[31:IDX_BITS+2], pc_f[1:0], pc_e[31:IDX_BITS+2], pc_e[1:0]};

  // No bypass: lookup always sees the registered entry.
  assign pred_taken = r_bht[w_idx_f][1];

  always_comb begin
    w_legal = 1'b1;
    w_cond  = 1'b0;
    case (f3)
      3'b000:  w_cond = zero;
      3'b001:  w_cond = ~zero;
      3'b100:  w_cond = neg;
      3'b101:  w_cond = ~neg;
      3'b110:  w_cond = ltu;
      3'b111:  w_cond = ~ltu;
      default: w_legal = 1'b0;
    endcase
  end

  assign w_update   = upd_valid & w_legal;
  assign taken_e    = w_update & w_cond;
  assign mispredict = w_update & (taken_e != pred_e);
  assign w_entry_e  = r_bht[w_idx_e];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Entries; i++) begin
        r_bht[i] <= INIT_STATE;
      end
      r_br_count   <= '0;
      r_miss_count <= '0;
    end else if (w_update) begin
      if (taken_e) begin
        if (w_entry_e != 2'b11) r_bht[w_idx_e] <= w_entry_e + 2'd1;
      end else begin
        if (w_entry_e != 2'b00) r_bht[w_idx_e] <= w_entry_e - 2'd1;
      end
      if (r_br_count != '1) r_br_count <= r_br_count + 1'b1;
      if (mispredict && (r_miss_count != '1)) r_miss_count <= r_miss_count + 1'b1;
    end
  end

  assign br_count   = r_br_count;
  assign miss_count = r_miss_count;

endmodule
